mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps {A1,A0} through 0..3, samples Y after each
// dwell, and reports the four bits as one word. Optional Y/NY check: MUX_SCAN_CHECK_EN.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       Y,
    input  logic       NY,
    output logic       A0,
    output logic       A1,
    output logic       busy,
    output logic       valid,
    output logic [3:0] result,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [7:0] LAST = 8'(SETTLE - 1);

    state_t     state, state_nx;
    logic [1:0] sel;
    logic [7:0] cnt;
    logic [3:0] cap;
    logic       dwell_end;
    logic       busy_nx;
    logic       valid_nx;

    assign dwell_end = (state == SCAN) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (dwell_end && (sel == 2'd3)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output strobes are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        busy_nx  = (state_nx == SCAN);
        valid_nx = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            busy  <= busy_nx;
            valid <= valid_nx;
        end
    end

    // sel drops back to 0 on the final sample so the mux select idles at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
            cnt <= '0;
            cap <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sel <= '0;
                    cnt <= '0;
                end
                SCAN: begin
                    if (!dwell_end) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cap[sel] <= Y;
                        cnt      <= '0;
                        sel      <= (sel == 2'd3) ? 2'd0 : sel + 2'd1;
                    end
                end
                default: begin
                    sel <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end

    assign A0 = sel[0];
    assign A1 = sel[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              result <= '0;
        else if (state == DONE)  result <= cap;
    end

`ifdef MUX_SCAN_CHECK_EN
    logic err_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (state == IDLE && start)
                err_acc <= 1'b0;
            else if (dwell_end && (Y == NY))
                err_acc <= 1'b1;
            if (state == DONE)
                err <= err_acc;
        end
    end
`else
    logic unused_ny;
    assign unused_ny = NY;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: two instances (SETTLE=2 and SETTLE=1),
// each fed by a behavioural 4:1 mux model driven from the bench's data word.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef MUX_SCAN_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    // instance a: SETTLE=2, instance b: SETTLE=1
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [3:0] d_a = '0, d_b = '0;
    logic       frc_a = 1'b0, frc_b = 1'b0;
    logic [1:0] fidx_a = '0, fidx_b = '0;
    logic       y_a, ny_a, y_b, ny_b;
    logic       a0_a, a1_a, busy_a, valid_a, err_a;
    logic       a0_b, a1_b, busy_b, valid_b, err_b;
    logic [3:0] res_a, res_b;

    assign y_a  = d_a[{a1_a, a0_a}];
    assign ny_a = (frc_a && {a1_a, a0_a} == fidx_a) ? y_a : ~y_a;
    assign y_b  = d_b[{a1_b, a0_b}];
    assign ny_b = (frc_b && {a1_b, a0_b} == fidx_b) ? y_b : ~y_b;

    mux_scan_ctrl #(.SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .Y(y_a), .NY(ny_a),
        .A0(a0_a), .A1(a1_a), .busy(busy_a), .valid(valid_a),
        .result(res_a), .err(err_a)
    );

    mux_scan_ctrl #(.SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .Y(y_b), .NY(ny_b),
        .A0(a0_b), .A1(a1_b), .busy(busy_b), .valid(valid_b),
        .result(res_b), .err(err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] sel_of(input int w);
        return (w == 0) ? {a1_a, a0_a} : {a1_b, a0_b};
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic valid_of(input int w);
        return (w == 0) ? valid_a : valid_b;
    endfunction
    function automatic logic [3:0] res_of(input int w);
        return (w == 0) ? res_a : res_b;
    endfunction
    function automatic logic err_of(input int w);
        return (w == 0) ? err_a : err_b;
    endfunction

    typedef struct {
        int         w;       // 0: SETTLE=2 instance, 1: SETTLE=1 instance
        logic [3:0] data;
        logic       frc;
        logic [1:0] fidx;
        logic       poke;    // extra start pulse mid-scan (must be ignored)
        logic [3:0] exp_res;
        logic       exp_err;
        string      nm;
    } vec_t;

    vec_t vecs[6];

    // One scan from a single-cycle start pulse; k counts edges after the start edge E0.
    task automatic run_scan(input vec_t v);
        int s = (v.w == 0) ? 2 : 1;
        int vat = -1;
        int vcnt = 0;
        int seq_bad = 0;
        @(negedge clk);
        if (v.w == 0) begin d_a = v.data; frc_a = v.frc; fidx_a = v.fidx; start_a = 1'b1; end
        else          begin d_b = v.data; frc_b = v.frc; fidx_b = v.fidx; start_b = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        for (int k = 0; k < 4 * s + 6; k++) begin
            if (k < 4 * s) begin
                if (sel_of(v.w) != 2'(k / s) || busy_of(v.w) !== 1'b1) seq_bad++;
            end else begin
                if (sel_of(v.w) != 2'd0 || busy_of(v.w) !== 1'b0) seq_bad++;
            end
            if (valid_of(v.w) === 1'b1) begin
                vcnt++;
                if (vat < 0) vat = k;
                chk({v.nm, "_result"}, 32'(res_of(v.w)), 32'(v.exp_res));
                chk({v.nm, "_err"}, 32'(err_of(v.w)), 32'(v.exp_err));
            end
            if (v.poke && k == 2) begin
                if (v.w == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            if (k == 3) begin start_a = 1'b0; start_b = 1'b0; end
            @(posedge clk); #1;
        end
        chk({v.nm, "_selseq"}, 32'(seq_bad), 32'd0);
        chk({v.nm, "_valid_edge"}, 32'(vat), 32'(4 * s + 1));
        chk({v.nm, "_valid_count"}, 32'(vcnt), 32'd1);
        chk({v.nm, "_result_hold"}, 32'(res_of(v.w)), 32'(v.exp_res));
        frc_a = 1'b0; frc_b = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 4'b1010, 1'b0, 2'd0, 1'b0, 4'b1010, 1'b0, "nominal"};
        vecs[1] = '{1, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b1111, 1'b0, "settle1"};
        vecs[2] = '{0, 4'b0110, 1'b1, 2'd2, 1'b0, 4'b0110, CHK,  "check_sel2"};
        vecs[3] = '{0, 4'b0110, 1'b0, 2'd0, 1'b0, 4'b0110, 1'b0, "check_clean"};
        vecs[4] = '{1, 4'b1001, 1'b1, 2'd0, 1'b0, 4'b1001, CHK,  "check_b_sel0"};
        vecs[5] = '{0, 4'b0011, 1'b0, 2'd0, 1'b1, 4'b0011, 1'b0, "poke_ignored"};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", 32'({a1_a, a0_a, busy_a, valid_a, res_a, err_a}), 32'd0);
        chk("rst_b", 32'({a1_b, a0_b, busy_b, valid_b, res_b, err_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_scan(vecs[i]);

        // start held through the scan and 3 cycles past valid: second scan starts at E0+10
        begin
            int v1 = -1, v2 = -1, vc = 0;
            logic busy10 = 1'b0;
            @(negedge clk);
            d_a = 4'b1010; start_a = 1'b1;
            @(posedge clk); #1;
            for (int k = 0; k < 26; k++) begin
                if (k == 10) busy10 = busy_a;
                if (valid_a) begin
                    vc++;
                    if (v1 < 0) v1 = k; else v2 = k;
                    chk("hold_result", 32'(res_a), 32'h0000000a);
                end
                if (k == 12) start_a = 1'b0;
                @(posedge clk); #1;
            end
            chk("hold_valid_count", 32'(vc), 32'd2);
            chk("hold_first_valid", 32'(v1), 32'd9);
            chk("hold_second_valid", 32'(v2), 32'd19);
            chk("hold_restart_busy", 32'(busy10), 32'd1);
        end

        // asynchronous reset two cycles into a scan
        begin
            int vc = 0;
            @(negedge clk);
            d_a = 4'b0101; start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            @(posedge clk);
            @(posedge clk); #2;
            chk("midrst_busy_before", 32'(busy_a), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("midrst_outputs", 32'({a1_a, a0_a, busy_a, valid_a, err_a}), 32'd0);
            chk("midrst_result", 32'(res_a), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                if (valid_a) vc++;
            end
            chk("midrst_no_valid", 32'(vc), 32'd0);
            chk("midrst_idle", 32'({a1_a, a0_a, busy_a}), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
